// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: shares the single register-file write port between the
// execute and load writeback paths using round-robin arbitration. It also
// tracks which registers still await a writeback, so decode can stall
// reads of those registers.
module rf_wb_scheduler #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_en,
  input  logic [REG_W-1:0]        alloc_reg,
  input  logic                    chk1_en,
  input  logic [REG_W-1:0]        chk1_sel,
  input  logic                    chk2_en,
  input  logic [REG_W-1:0]        chk2_sel,
  output logic                    hazard,
  input  logic                    req0_valid,
  input  logic [REG_W-1:0]        req0_reg,
  input  logic [DATA_W-1:0]       req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [REG_W-1:0]        req1_reg,
  input  logic [DATA_W-1:0]       req1_data,
  output logic                    req1_ready,
  output logic                    rf_writeEn,
  output logic [REG_W-1:0]        rf_writeRegSel,
  output logic [DATA_W-1:0]       rf_writeData,
  output logic [(1<<REG_W)-1:0]   pending,
  output logic                    err
);

  localparam int NREG = 1 << REG_W;

  typedef enum logic {
    GNT_REQ0 = 1'b0,
    GNT_REQ1 = 1'b1
  } gnt_idx_e;

  gnt_idx_e          last_q, last_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              err_q, err_d;

  logic              gnt0, gnt1;
  logic              wr_en;
  logic [REG_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   clr_mask, set_mask;
  logic              hit1, hit2;
  logic              waw_err, stray_err;

  // Round-robin grant. Nothing is granted while reset is held, so that a
  // request still in flight cannot reach the register file.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        if (last_q == GNT_REQ1) gnt0 = 1'b1;
        else                    gnt1 = 1'b1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  // Write-port mux. The select and data lines are forced to zero when
  // nothing is granted.
  always_comb begin
    wr_en   = gnt0 | gnt1;
    wr_sel  = '0;
    wr_data = '0;
    if (gnt0) begin
      wr_sel  = req0_reg;
      wr_data = req0_data;
    end else if (gnt1) begin
      wr_sel  = req1_reg;
      wr_data = req1_data;
    end
  end

  // Read-hazard detection. A pending source that is being written in this
  // cycle is forwarded by the register-file bypass, so it does not stall.
  always_comb begin
    hit1   = chk1_en && pending_q[chk1_sel] && !(wr_en && wr_sel == chk1_sel);
    hit2   = chk2_en && pending_q[chk2_sel] && !(wr_en && wr_sel == chk2_sel);
    hazard = !rst && (hit1 || hit2);
  end

  // Next state for the scoreboard, the error flag and the pointer. The mask
  // order makes a new allocation win over the clear of an old producer.
  always_comb begin
    clr_mask  = wr_en    ? (NREG'(1) << wr_sel)    : '0;
    set_mask  = alloc_en ? (NREG'(1) << alloc_reg) : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    waw_err   = alloc_en && pending_q[alloc_reg] && !(wr_en && wr_sel == alloc_reg);
    stray_err = wr_en && !pending_q[wr_sel];
    err_d     = err_q | waw_err | stray_err;
    last_d    = last_q;
    if (gnt0)      last_d = GNT_REQ0;
    else if (gnt1) last_d = GNT_REQ1;
  end

  // State registers. The pointer resets to requester 1, so requester 0
  // wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples values from before the clock edge.
      pending_q <= '0;
      err_q     <= 1'b0;
      last_q    <= GNT_REQ1;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
      last_q    <= last_d;
    end
  end

  assign req0_ready     = gnt0;
  assign req1_ready     = gnt1;
  assign rf_writeEn     = wr_en;
  assign rf_writeRegSel = wr_sel;
  assign rf_writeData   = wr_data;
  assign pending        = pending_q;
  assign err            = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Testbench for rf_wb_scheduler. Table-driven vectors cover allocation,
// arbitration, hazards and errors. Expected writes go into a scoreboard
// queue, and a hand-written sequence checks an asynchronous reset that
// arrives in the middle of a cycle.
module tb_rf_wb_scheduler;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam int   NV = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_en;
  logic [2:0]  alloc_reg;
  logic        chk1_en;
  logic [2:0]  chk1_sel;
  logic        chk2_en;
  logic [2:0]  chk2_sel;
  logic        hazard;
  logic        req0_valid;
  logic [2:0]  req0_reg;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [2:0]  req1_reg;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        rf_writeEn;
  logic [2:0]  rf_writeRegSel;
  logic [15:0] rf_writeData;
  logic [7:0]  pending;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ae;
    logic [2:0]  ar;
    logic        c1e;
    logic [2:0]  c1s;
    logic        c2e;
    logic [2:0]  c2s;
    logic        v0;
    logic [2:0]  r0;
    logic [15:0] d0;
    logic        v1;
    logic [2:0]  r1;
    logic [15:0] d1;
    logic        e_haz;
    logic        e_g0;
    logic        e_g1;
    logic [7:0]  e_pend;
    logic        e_err;
  } vec_t;

  vec_t        vecs [NV];
  logic [18:0] sb_q [$];

  rf_wb_scheduler #(.DATA_W(16), .REG_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_en       (alloc_en),
    .alloc_reg      (alloc_reg),
    .chk1_en        (chk1_en),
    .chk1_sel       (chk1_sel),
    .chk2_en        (chk2_en),
    .chk2_sel       (chk2_sel),
    .hazard         (hazard),
    .req0_valid     (req0_valid),
    .req0_reg       (req0_reg),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_reg       (req1_reg),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .rf_writeEn     (rf_writeEn),
    .rf_writeRegSel (rf_writeRegSel),
    .rf_writeData   (rf_writeData),
    .pending        (pending),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alloc_en = N; alloc_reg = 3'd0;
    chk1_en = N; chk1_sel = 3'd0; chk2_en = N; chk2_sel = 3'd0;
    req0_valid = N; req0_reg = 3'd0; req0_data = 16'h0;
    req1_valid = N; req1_reg = 3'd0; req1_data = 16'h0;
  endtask

  // Drive one vector away from the clock edge, check the combinational
  // outputs, then check the registered state after the next rising edge.
  task automatic apply(input int idx);
    vec_t        v;
    logic [18:0] exp_wr;
    v = vecs[idx];
    @(negedge clk);
    alloc_en = v.ae; alloc_reg = v.ar;
    chk1_en = v.c1e; chk1_sel = v.c1s; chk2_en = v.c2e; chk2_sel = v.c2s;
    req0_valid = v.v0; req0_reg = v.r0; req0_data = v.d0;
    req1_valid = v.v1; req1_reg = v.r1; req1_data = v.d1;
    if (v.e_g0)      sb_q.push_back({v.r0, v.d0});
    else if (v.e_g1) sb_q.push_back({v.r1, v.d1});
    #1;
    check($sformatf("v%0d hazard", idx), 32'(hazard), 32'(v.e_haz));
    check($sformatf("v%0d ready0", idx), 32'(req0_ready), 32'(v.e_g0));
    check($sformatf("v%0d ready1", idx), 32'(req1_ready), 32'(v.e_g1));
    check($sformatf("v%0d writeEn", idx), 32'(rf_writeEn), 32'(v.e_g0 | v.e_g1));
    if (rf_writeEn) begin
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d unexpected_write", idx), 32'(rf_writeRegSel), 32'hFFFF_FFFF);
      end else begin
        exp_wr = sb_q.pop_front();
        check($sformatf("v%0d wr_sel", idx), 32'(rf_writeRegSel), 32'(exp_wr[18:16]));
        check($sformatf("v%0d wr_data", idx), 32'(rf_writeData), 32'(exp_wr[15:0]));
      end
    end else begin
      check($sformatf("v%0d idle_port", idx), {13'b0, rf_writeRegSel, rf_writeData}, 32'h0);
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d pending", idx), 32'(pending), 32'(v.e_pend));
    check($sformatf("v%0d err", idx), 32'(err), 32'(v.e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //               ae ar     c1e c1s    c2e c2s    v0 r0     d0        v1 r1     d1        haz g0 g1 pend   err
    vecs[0]  = '{Y, 3'd3, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h08, N};
    vecs[1]  = '{N, 3'd0, Y, 3'd3, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, Y, N, N, 8'h08, N};
    vecs[2]  = '{N, 3'd0, Y, 3'd3, N, 3'd0, Y, 3'd3, 16'hBEEF, N, 3'd0, 16'h0000, N, Y, N, 8'h00, N};
    vecs[3]  = '{Y, 3'd1, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h02, N};
    vecs[4]  = '{Y, 3'd2, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h06, N};
    vecs[5]  = '{Y, 3'd7, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h86, N};
    vecs[6]  = '{N, 3'd0, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, Y, 3'd7, 16'h7777, N, N, Y, 8'h06, N};
    vecs[7]  = '{N, 3'd0, N, 3'd0, N, 3'd0, Y, 3'd1, 16'h1111, Y, 3'd2, 16'h2222, N, Y, N, 8'h04, N};
    vecs[8]  = '{N, 3'd0, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, Y, 3'd2, 16'h2222, N, N, Y, 8'h00, N};
    vecs[9]  = '{Y, 3'd0, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h01, N};
    vecs[10] = '{Y, 3'd1, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h03, N};
    vecs[11] = '{Y, 3'd2, N, 3'd0, N, 3'd0, Y, 3'd0, 16'hA000, Y, 3'd1, 16'hA001, N, Y, N, 8'h06, N};
    vecs[12] = '{Y, 3'd3, N, 3'd0, N, 3'd0, Y, 3'd2, 16'hA002, Y, 3'd1, 16'hA001, N, N, Y, 8'h0C, N};
    vecs[13] = '{Y, 3'd4, N, 3'd0, N, 3'd0, Y, 3'd2, 16'hA002, Y, 3'd3, 16'hA003, N, Y, N, 8'h18, N};
    vecs[14] = '{N, 3'd0, Y, 3'd3, Y, 3'd4, Y, 3'd4, 16'hA004, Y, 3'd3, 16'hA003, Y, N, Y, 8'h10, N};
    vecs[15] = '{Y, 3'd5, N, 3'd0, N, 3'd0, Y, 3'd4, 16'hA004, N, 3'd0, 16'h0000, N, Y, N, 8'h20, N};
    vecs[16] = '{Y, 3'd5, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, Y, 3'd5, 16'h5555, N, N, Y, 8'h20, N};
    vecs[17] = '{N, 3'd0, Y, 3'd5, Y, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, Y, N, N, 8'h20, N};
    vecs[18] = '{Y, 3'd4, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h30, N};
    vecs[19] = '{Y, 3'd4, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h30, Y};
    vecs[20] = '{N, 3'd0, N, 3'd0, N, 3'd0, Y, 3'd4, 16'h4444, N, 3'd0, 16'h0000, N, Y, N, 8'h20, Y};
    vecs[21] = '{Y, 3'd0, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h21, Y};
    vecs[22] = '{Y, 3'd1, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h23, Y};
    vecs[23] = '{Y, 3'd2, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h27, Y};
    vecs[24] = '{Y, 3'd3, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h2F, Y};
    vecs[25] = '{Y, 3'd4, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h3F, Y};
    vecs[26] = '{Y, 3'd6, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'h7F, Y};
    vecs[27] = '{Y, 3'd7, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, N, 3'd0, 16'h0000, N, N, N, 8'hFF, Y};
    // After a mid-cycle reset: the first contention goes to req0, and a write
    // to a register that is not pending raises err while still writing.
    vecs[28] = '{N, 3'd0, N, 3'd0, N, 3'd0, Y, 3'd6, 16'h6666, Y, 3'd7, 16'h7777, N, Y, N, 8'h00, Y};
    vecs[29] = '{N, 3'd0, N, 3'd0, N, 3'd0, N, 3'd0, 16'h0000, Y, 3'd7, 16'h7777, N, N, Y, 8'h00, Y};

    // Hold reset with a request pending; no grant may leak out.
    idle_inputs();
    rst = Y;
    req0_valid = Y; req0_reg = 3'd3; req0_data = 16'h1234;
    #12;
    check("rst_ready0", 32'(req0_ready), 32'h0);
    check("rst_writeEn", 32'(rf_writeEn), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    req0_valid = N;
    @(negedge clk);
    rst = N;

    for (int i = 0; i < 28; i++) apply(i);

    // Assert reset asynchronously in the middle of a cycle while pending
    // is full and both requesters are valid.
    @(negedge clk);
    req0_valid = Y; req0_reg = 3'd0; req0_data = 16'hC0C0;
    req1_valid = Y; req1_reg = 3'd1; req1_data = 16'hC1C1;
    chk1_en = Y; chk1_sel = 3'd2;
    #1;
    check("pre_rst_writeEn", 32'(rf_writeEn), 32'h1);
    #2;
    rst = Y;
    #1;
    check("mid_rst_pending", 32'(pending), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_ready0", 32'(req0_ready), 32'h0);
    check("mid_rst_ready1", 32'(req1_ready), 32'h0);
    check("mid_rst_writeEn", 32'(rf_writeEn), 32'h0);
    check("mid_rst_hazard", 32'(hazard), 32'h0);
    @(posedge clk);
    #1;
    check("held_rst_pending", 32'(pending), 32'h0);
    check("held_rst_ready1", 32'(req1_ready), 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = N;

    for (int i = 28; i < NV; i++) apply(i);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
